// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and shifts them out as 8N1/8N2 frames, LSB first.
module uart_tx_serializer #(
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en_i,
  input  logic        fifo_empty_i,
  input  logic [7:0]  fifo_data_i,
  output logic        fifo_rd_en_o,
  input  logic [31:0] baud_div_i,
  output logic        txd_o,
  output logic        busy_o,
  output logic        frame_done_o
);
  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, STOP} state_t;
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  state_t state, state_n;
  logic [7:0] sh, sh_n;
  logic [31:0] div, div_n, cnt, cnt_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic stop_cnt, stop_cnt_n;
  logic txd_n, rd_n, busy_n, done_n, tick;
  assign tick = cnt == div - 32'd1;
  always_comb begin
    state_n = state;
    sh_n = sh;
    div_n = div;
    cnt_n = cnt;
    bit_cnt_n = bit_cnt;
    stop_cnt_n = stop_cnt;
    txd_n = txd_o;
    rd_n = 1'b0;
    busy_n = busy_o;
    done_n = 1'b0;
    unique case (state)
      IDLE: if (tx_en_i && !fifo_empty_i) begin
        state_n = POP;
        rd_n = 1'b1;
        busy_n = 1'b1;
      end
      POP: state_n = LOAD;
      LOAD: begin
        sh_n = fifo_data_i;
        div_n = baud_div_i == 32'd0 ? 32'd1 : baud_div_i;
        txd_n = 1'b0;
        bit_cnt_n = 4'd0;
        cnt_n = 32'd0;
        stop_cnt_n = 1'b0;
        state_n = SHIFT;
      end
      SHIFT: begin
        cnt_n = tick ? 32'd0 : cnt + 32'd1;
        if (tick && bit_cnt == 4'd8) begin
          txd_n = 1'b1;
          state_n = STOP;
        end else if (tick) begin
          txd_n = sh[0];
          sh_n = sh >> 1;
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      STOP: begin
        cnt_n = tick ? 32'd0 : cnt + 32'd1;
        if (tick && stop_cnt == LAST_STOP) begin
          done_n = 1'b1;
          busy_n = 1'b0;
          state_n = IDLE;
        end else if (tick) stop_cnt_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= 8'd0;
      div <= 32'd1;
      cnt <= 32'd0;
      bit_cnt <= 4'd0;
      stop_cnt <= 1'b0;
      txd_o <= 1'b1;
      fifo_rd_en_o <= 1'b0;
      busy_o <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      div <= div_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      txd_o <= txd_n;
      fifo_rd_en_o <= rd_n;
      busy_o <= busy_n;
      frame_done_o <= done_n;
    end
  end
endmodule
